// File: rtl/montgomery_rr_arbiter.sv
// Round-robin arbiter sharing one 2-stage Montgomery reducer among NUM_REQ NTT lanes; results return in issue order.
// Latency: 3 cycles from request accept to rsp_valid when unstalled; 1 op/cycle, at most 3 ops held.
// Backpressure: rsp_valid & ~rsp_ready freezes issue reg, tags, rr_ptr and the reducer (mr_en=0); req_ready drops.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   flush               sync discard of all in-flight operations
//   req_valid/ready     per-lane operand handshake, req_data lane i at [32*i+31:32*i]
//   rsp_valid/ready     result handshake with rsp_data (residue 0..2q-1) and rsp_id
//   mr_*                reducer control/operand out, result/valid in
//   busy, done_cnt      activity flag and accepted-response counter (wraps)
module montgomery_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   mr_en,
  output logic                   mr_load,
  output logic                   mr_reset,
  output logic [31:0]            mr_in,
  input  logic [15:0]            mr_out,
  input  logic                   mr_valid,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_cnt
);

  logic            rst_hold;     // high in reset and for the first cycle after release
  logic            stall;
  logic            arb_en;
  logic [ID_W-1:0] rr_ptr;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;

  logic            issue_load;
  logic [31:0]     issue_data;
  logic [ID_W-1:0] issue_id;

  logic [1:0]      tag_vld;
  logic [ID_W-1:0] tag_id [2];

  // Reducer reset stays asserted one cycle past release so it comes up clean
  // even though its reset is synchronous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_hold <= 1'b1;
    else          rst_hold <= 1'b0;
  end

  assign mr_reset  = rst_hold | flush;
  // Gate with rst_hold: the reducer may still show a stale valid while reset_n is low.
  assign rsp_valid = mr_valid & ~rst_hold;
  assign rsp_data  = mr_out;
  assign rsp_id    = tag_id[1];
  assign stall     = rsp_valid & ~rsp_ready;
  // Reset/flush must reach the reducer even while the consumer is stalling.
  assign mr_en     = ~stall | mr_reset;
  assign arb_en    = ~stall & ~flush & ~rst_hold;
  assign mr_load   = issue_load;
  assign mr_in     = issue_data;
  assign busy      = issue_load | (|tag_vld) | rsp_valid;

  // Round-robin search starting one past the last granted lane.
  always_comb begin : arb
    int              idx;
    logic [ID_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx  = (int'(rr_ptr) + off) % NUM_REQ;
      cand = ID_W'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (arb_en && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      issue_load <= 1'b0;
      issue_data <= '0;
      issue_id   <= '0;
    end else if (flush) begin
      issue_load <= 1'b0;
    end else if (!stall) begin
      issue_load <= arb_en & gnt_found;
      if (arb_en && gnt_found) begin
        rr_ptr     <= gnt_idx;
        issue_data <= req_data[32*gnt_idx +: 32];
        issue_id   <= gnt_idx;
      end
    end
  end

  // ID shadow of the reducer pipeline; moves exactly when the reducer does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld   <= '0;
      tag_id[0] <= '0;
      tag_id[1] <= '0;
    end else if (mr_reset) begin
      tag_vld   <= '0;
      tag_id[0] <= '0;
      tag_id[1] <= '0;
    end else if (mr_en) begin
      tag_vld   <= {tag_vld[0], issue_load};
      tag_id[0] <= issue_id;
      tag_id[1] <= tag_id[0];
    end
  end

  // Counts accepts even in a flush cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    done_cnt <= '0;
    else if (rsp_valid && rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_montgomery_rr_arbiter.sv
module tb_montgomery_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 16;
  localparam int ID_W    = 2;
  localparam int Q       = 3329;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  flush;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  mr_en, mr_load, mr_reset;
  logic [31:0]           mr_in;
  logic [15:0]           mr_out;
  logic                  mr_valid;
  logic                  busy;
  logic [CNT_W-1:0]      done_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  montgomery_rr_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .mr_en(mr_en), .mr_load(mr_load), .mr_reset(mr_reset), .mr_in(mr_in),
    .mr_out(mr_out), .mr_valid(mr_valid), .busy(busy), .done_cnt(done_cnt)
  );

  // Behavioural Montgomery reducer, R = 2^18, two enabled stages.
  function automatic logic [15:0] redc(input logic [31:0] t);
    logic [17:0] x, m;
    logic [49:0] s;
    x = 18'(Q);
    for (int i = 0; i < 5; i++) x = x * (18'd2 - 18'(Q) * x);
    m = t[17:0] * (~x + 18'd1);
    s = {18'd0, t} + 50'(m) * 50'(Q);
    return s[33:18];
  endfunction

  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [15:0] s1_d = '0, s2_d = '0;
  always_ff @(posedge clk) begin
    if (mr_reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (mr_en) begin
      s1_v <= mr_load;
      s1_d <= redc(mr_in);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign mr_valid = s2_v;
  assign mr_out   = s2_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: expected {id, k} pushed on every accepted request, popped on every accepted response.
  logic [17:0] sb[$];
  logic [17:0] sb_e;
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        sb_e = sb.pop_front();
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, sb_e[15:0]});
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, sb_e[17:16]});
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i])
        sb.push_back({2'(i), 16'(req_data[32*i +: 32] >> 18)});
    if (flush || !reset_n) sb.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input int k);
    req_data[32*lane +: 32] = 32'(k) << 18;
  endtask

  task automatic wait_grant(input int lane);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (req_ready[lane]) got = 1'b1;
    end
    chk("grant_wait", {31'd0, got}, 32'd1);
    step();
  endtask

  initial begin
    int  rr_exp;
    bit  hit;
    reset_n = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mr_load", {31'd0, mr_load}, 32'd0);
    chk("rst_mr_in", mr_in, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("rst_mr_reset", {31'd0, mr_reset}, 32'd1);
    chk("rst_mr_en", {31'd0, mr_en}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_mr_reset_hold", {31'd0, mr_reset}, 32'd1);
    step();
    @(negedge clk);
    chk("rel_mr_reset_off", {31'd0, mr_reset}, 32'd0);
    step();

    // Single op, lane 0, latency 3
    req_data[31:0] = 32'h0004_0000;
    req_valid = 4'b0001;
    wait_grant(0);
    req_valid = '0;
    @(negedge clk); chk("lat1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); chk("lat2_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); chk("lat3_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk); chk("done_cnt_1", {16'd0, done_cnt}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    step();

    // All lanes streaming for 8 cycles
    rr_exp = 0;
    for (int l = 0; l < NUM_REQ; l++) set_lane(l, l + 1);
    req_valid = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 8) begin
        rr_exp = (rr_exp + 1) % NUM_REQ;
        chk("rr_grant", {28'd0, req_ready}, 32'd1 << rr_exp);
      end
      if (i >= 3 && i <= 10) chk("stream_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      if (i == 11) chk("stream_drained", {31'd0, rsp_valid}, 32'd0);
      step();
      if (i == 7) req_valid = '0;
    end

    // Lane 2 stream with 4-cycle consumer stall on the first response
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      set_lane(2, 5 + i);
      @(negedge clk);
      chk("single_grant", {28'd0, req_ready}, 32'h4);
      step();
    end
    req_valid = 4'b0001;
    set_lane(0, 9);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", {16'd0, rsp_data}, 32'd5);
      chk("stall_req_ready", {28'd0, req_ready}, 32'd0);
      chk("stall_mr_en", {31'd0, mr_en}, 32'd0);
      chk("stall_done_cnt", {16'd0, done_cnt}, 32'd9);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_stall_grant", {28'd0, req_ready}, 32'h1);
    chk("post_stall_valid", {31'd0, rsp_valid}, 32'd1);
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_stall_burst", {31'd0, rsp_valid}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("post_stall_count", {16'd0, done_cnt}, 32'd13);
    step();

    // Flush with three ops held
    req_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      set_lane(3, 1 + i);
      @(negedge clk);
      chk("flush_fill_grant", {28'd0, req_ready}, 32'h8);
      step();
    end
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", {28'd0, req_ready}, 32'd0);
    chk("flush_mr_reset", {31'd0, mr_reset}, 32'd1);
    chk("flush_mr_en", {31'd0, mr_en}, 32'd1);
    step();
    flush = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      if (i == 0) begin
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done_cnt", {16'd0, done_cnt}, 32'd13);
      end
      step();
    end
    set_lane(1, 11);
    req_valid = 4'b0010;
    wait_grant(1);
    req_valid = '0;
    repeat (4) step();
    @(negedge clk);
    chk("post_flush_count", {16'd0, done_cnt}, 32'd14);
    step();

    // Reset mid-stream
    set_lane(0, 12);
    set_lane(1, 13);
    req_valid = 4'b0011;
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_mr_load", {31'd0, mr_load}, 32'd0);
    chk("mid_rst_mr_in", mr_in, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("mid_rst_mr_reset", {31'd0, mr_reset}, 32'd1);
    req_valid = '0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
      step();
    end

    // Counter wrap with all lanes streaming
    for (int l = 0; l < NUM_REQ; l++) set_lane(l, l + 1);
    req_valid = 4'hF;
    hit = 1'b0;
    for (int n = 0; n < 70000 && !hit; n++) begin
      @(negedge clk);
      if (done_cnt == 16'hFFFF && rsp_valid && rsp_ready) hit = 1'b1;
    end
    chk("wrap_reached", {31'd0, hit}, 32'd1);
    @(negedge clk);
    chk("wrap_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("wrap_busy", {31'd0, busy}, 32'd1);
    chk("wrap_arb_onehot", 32'($countones(req_ready)), 32'd1);
    step();
    req_valid = '0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (!busy) hit = 1'b1;
    end
    chk("drain_idle", {31'd0, hit}, 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
